// File: rtl/logic_reduce_acc_if.sv
// Producer/consumer bus for logic_reduce_acc.
// Optional macro LOGIC_REDUCE_ONES_EN adds the ones_cnt result field.
interface logic_reduce_acc_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 5
);
`ifdef LOGIC_REDUCE_ONES_EN
    localparam int ONES_W = $clog2(WIDTH + 1);
`endif

    // Producer side
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_last;
    logic [1:0]       mode;
    logic             in_ready;

    // Consumer side
    logic [WIDTH-1:0] res_vec;
    logic             res;
    logic [CNT_W-1:0] frame_len;
    logic             ovf;
    logic             out_valid;
    logic             out_ready;
`ifdef LOGIC_REDUCE_ONES_EN
    logic [ONES_W-1:0] ones_cnt;
`endif

    // Environment: drives words and consumes results
    modport master (
        output in_data, in_valid, in_last, mode, out_ready,
        input  in_ready, res_vec, res, frame_len, ovf, out_valid
`ifdef LOGIC_REDUCE_ONES_EN
        , input ones_cnt
`endif
    );

    // Reduction block
    modport slave (
        input  in_data, in_valid, in_last, mode, out_ready,
        output in_ready, res_vec, res, frame_len, ovf, out_valid
`ifdef LOGIC_REDUCE_ONES_EN
        , output ones_cnt
`endif
    );
endinterface

// File: rtl/logic_reduce_acc.sv
// Registered frame reducer: folds a stream of WIDTH-bit words into an accumulated
// vector plus a single reduced bit, mode (AND/OR/XOR/NAND) latched per frame.
// Optional macro LOGIC_REDUCE_ONES_EN adds ones_cnt, the popcount of res_vec.
module logic_reduce_acc #(
    parameter int WIDTH     = 4,
    parameter int MAX_WORDS = 16,
    parameter int CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input logic                clk,
    input logic                rst_n,
    logic_reduce_acc_if.slave  bus
);
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StAccum = 2'd1;
    localparam logic [1:0] StHold  = 2'd2;

    localparam logic [1:0] ModeAnd  = 2'b00;
    localparam logic [1:0] ModeOr   = 2'b01;
    localparam logic [1:0] ModeXor  = 2'b10;
    localparam logic [1:0] ModeNand = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] res_vec_q, res_vec_d;
    logic             res_q, res_d;
    logic [CNT_W-1:0] frame_len_q, frame_len_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready;
    logic             accept;
    logic             done;

    // NAND accumulates as AND; the inversion is applied only to the result
    function automatic logic [WIDTH-1:0] combine(input logic [1:0] m,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        case (m)
            ModeOr:  return a | b;
            ModeXor: return a ^ b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic reduce_bits(input logic [1:0] m, input logic [WIDTH-1:0] v);
        case (m)
            ModeAnd: return &v;
            ModeOr:  return |v;
            ModeXor: return ^v;
            default: return ~&v;
        endcase
    endfunction

    // in_ready depends on state only, never on in_valid/out_ready
    assign in_ready = (state_q != StHold);
    assign accept   = bus.in_valid && in_ready;

    // Next-state: frame accumulation, termination and result capture
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        res_vec_d   = res_vec_q;
        res_d       = res_q;
        frame_len_d = frame_len_q;
        done        = 1'b0;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    acc_d  = bus.in_data;
                    mode_d = bus.mode;
                    cnt_d  = CNT_W'(1);
                    ovf_d  = 1'b0;
                    if (bus.in_last || (MAX_WORDS == 1)) begin
                        state_d = StHold;
                        done    = 1'b1;
                        // Only a single-word limit can force-terminate here
                        ovf_d   = !bus.in_last;
                    end else begin
                        state_d = StAccum;
                    end
                end
            end
            StAccum: begin
                if (accept) begin
                    acc_d = combine(mode_q, acc_q, bus.in_data);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (bus.in_last) begin
                        state_d = StHold;
                        done    = 1'b1;
                    end else if (cnt_d == CNT_W'(MAX_WORDS)) begin
                        state_d = StHold;
                        done    = 1'b1;
                        ovf_d   = 1'b1;
                    end
                end
            end
            StHold: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // res reduces res_vec (already inverted in NAND mode) with the frame's mode
        if (done) begin
            out_valid_d = 1'b1;
            res_vec_d   = (mode_d == ModeNand) ? ~acc_d : acc_d;
            res_d       = reduce_bits(mode_d, res_vec_d);
            frame_len_d = cnt_d;
        end
    end

    // State and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            mode_q      <= ModeAnd;
            res_vec_q   <= '0;
            res_q       <= 1'b0;
            frame_len_q <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            res_vec_q   <= res_vec_d;
            res_q       <= res_d;
            frame_len_q <= frame_len_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef LOGIC_REDUCE_ONES_EN
    localparam int ONES_W = $clog2(WIDTH + 1);
    logic [ONES_W-1:0] ones_q, ones_d;

    // Popcount of the next res_vec, so it lands on the same edge as res_vec
    always_comb begin
        ones_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones_d = ones_d + ONES_W'(res_vec_d[i]);
        end
    end

    // Popcount register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_q <= '0;
        end else begin
            ones_q <= ones_d;
        end
    end

    assign bus.ones_cnt = ones_q;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.res_vec   = res_vec_q;
    assign bus.res       = res_q;
    assign bus.frame_len = frame_len_q;
    assign bus.ovf       = ovf_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_logic_reduce_acc.sv
// Directed bench for logic_reduce_acc (WIDTH=4, MAX_WORDS=4).
// Build with LOGIC_REDUCE_ONES_EN to also cover ones_cnt.
module tb_logic_reduce_acc;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic_reduce_acc_if #(.WIDTH(4), .CNT_W(3)) bus ();

    logic_reduce_acc #(
        .WIDTH    (4),
        .MAX_WORDS(4),
        .CNT_W    (3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    // Present one word and hold it until accepted (bounded), leave at posedge+1
    task automatic send(input logic [3:0] d, input logic last, input logic [1:0] m);
        int n = 0;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.mode     = m;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: in_ready=%b want 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Consume the pending result for one cycle
    task automatic drain(input string name);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain_valid: out_valid=%b want 0", name, bus.out_valid);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_drain_ready: in_ready=%b want 1", name, bus.in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b1;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.mode      = 2'b00;
        bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.res_vec !== 4'b0000) begin errors++; $display("FAIL rst_res_vec: got %b want 0000", bus.res_vec); end
        checks++; if (bus.res !== 1'b0) begin errors++; $display("FAIL rst_res: got %b want 0", bus.res); end
        checks++; if (bus.frame_len !== 3'd0) begin errors++; $display("FAIL rst_frame_len: got %0d want 0", bus.frame_len); end
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", bus.ovf); end
`ifdef LOGIC_REDUCE_ONES_EN
        checks++; if (bus.ones_cnt !== 3'd0) begin errors++; $display("FAIL rst_ones: got %0d want 0", bus.ones_cnt); end
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        send(4'b0000, 1'b1, 2'b01);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", bus.out_valid); end
        checks++; if (bus.res_vec !== 4'b0000) begin errors++; $display("FAIL single_vec: got %b want 0000", bus.res_vec); end
        checks++; if (bus.res !== 1'b0) begin errors++; $display("FAIL single_res: got %b want 0", bus.res); end
        checks++; if (bus.frame_len !== 3'd1) begin errors++; $display("FAIL single_len: got %0d want 1", bus.frame_len); end
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL single_ovf: got %b want 0", bus.ovf); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL single_in_ready: got %b want 0", bus.in_ready); end
        drain("single");
    endtask

    task automatic test_and_hold();
        send(4'b1111, 1'b0, 2'b00);
        send(4'b0110, 1'b0, 2'b00);
        send(4'b1110, 1'b1, 2'b00);
        // Offer a stray word while held; it must not be taken
        bus.in_data  = 4'b0000;
        bus.in_last  = 1'b1;
        bus.mode     = 2'b01;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL hold%0d_valid: got %b want 1", c, bus.out_valid); end
            checks++; if (bus.res_vec !== 4'b0110) begin errors++; $display("FAIL hold%0d_vec: got %b want 0110", c, bus.res_vec); end
            checks++; if (bus.res !== 1'b0) begin errors++; $display("FAIL hold%0d_res: got %b want 0", c, bus.res); end
            checks++; if (bus.frame_len !== 3'd3) begin errors++; $display("FAIL hold%0d_len: got %0d want 3", c, bus.frame_len); end
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL hold%0d_in_ready: got %b want 0", c, bus.in_ready); end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        drain("and");
        // Result retained after draining
        checks++; if (bus.res_vec !== 4'b0110) begin errors++; $display("FAIL and_retain: got %b want 0110", bus.res_vec); end
    endtask

    task automatic test_xor_nand();
        send(4'b1010, 1'b0, 2'b10);
        send(4'b0110, 1'b1, 2'b10);
        checks++; if (bus.res_vec !== 4'b1100) begin errors++; $display("FAIL xor_vec: got %b want 1100", bus.res_vec); end
        checks++; if (bus.res !== 1'b0) begin errors++; $display("FAIL xor_res: got %b want 0", bus.res); end
        drain("xor");
        send(4'b1111, 1'b0, 2'b11);
        send(4'b1111, 1'b1, 2'b11);
        checks++; if (bus.res_vec !== 4'b0000) begin errors++; $display("FAIL nand_vec: got %b want 0000", bus.res_vec); end
        checks++; if (bus.res !== 1'b1) begin errors++; $display("FAIL nand_res: got %b want 1", bus.res); end
        drain("nand");
        // XOR frame with OR requested on the second word: 0011^0101=0110
        send(4'b0011, 1'b0, 2'b10);
        send(4'b0101, 1'b1, 2'b01);
        checks++; if (bus.res_vec !== 4'b0110) begin errors++; $display("FAIL modechg_vec: got %b want 0110", bus.res_vec); end
        checks++; if (bus.res !== 1'b0) begin errors++; $display("FAIL modechg_res: got %b want 0", bus.res); end
        drain("modechg");
    endtask

    task automatic test_ovf();
        for (int i = 0; i < 3; i++) send(4'b0001, 1'b0, 2'b01);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ovf_early_valid: got %b want 0", bus.out_valid); end
        send(4'b0001, 1'b0, 2'b01);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %b want 1", bus.out_valid); end
        checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", bus.ovf); end
        checks++; if (bus.frame_len !== 3'd4) begin errors++; $display("FAIL ovf_len: got %0d want 4", bus.frame_len); end
        checks++; if (bus.res_vec !== 4'b0001) begin errors++; $display("FAIL ovf_vec: got %b want 0001", bus.res_vec); end
        checks++; if (bus.res !== 1'b1) begin errors++; $display("FAIL ovf_res: got %b want 1", bus.res); end
        drain("ovf");
        send(4'b0010, 1'b1, 2'b01);
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", bus.ovf); end
        checks++; if (bus.frame_len !== 3'd1) begin errors++; $display("FAIL ovf_next_len: got %0d want 1", bus.frame_len); end
        drain("ovfnext");
        // in_last on the MAX_WORDS-th word is a normal completion
        send(4'b0001, 1'b0, 2'b01);
        send(4'b0010, 1'b0, 2'b01);
        send(4'b0100, 1'b0, 2'b01);
        send(4'b1000, 1'b1, 2'b01);
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL lastmax_ovf: got %b want 0", bus.ovf); end
        checks++; if (bus.frame_len !== 3'd4) begin errors++; $display("FAIL lastmax_len: got %0d want 4", bus.frame_len); end
        checks++; if (bus.res_vec !== 4'b1111) begin errors++; $display("FAIL lastmax_vec: got %b want 1111", bus.res_vec); end
        drain("lastmax");
    endtask

    task automatic test_reset_mid();
        send(4'b0001, 1'b0, 2'b01);
        send(4'b0010, 1'b0, 2'b01);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.res_vec !== 4'b0000) begin errors++; $display("FAIL rstmid_vec: got %b want 0000", bus.res_vec); end
        checks++; if (bus.frame_len !== 3'd0) begin errors++; $display("FAIL rstmid_len: got %0d want 0", bus.frame_len); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(4'b1000, 1'b1, 2'b01);
        checks++; if (bus.res_vec !== 4'b1000) begin errors++; $display("FAIL rstmid_new_vec: got %b want 1000", bus.res_vec); end
        checks++; if (bus.frame_len !== 3'd1) begin errors++; $display("FAIL rstmid_new_len: got %0d want 1", bus.frame_len); end
        checks++; if (bus.res !== 1'b1) begin errors++; $display("FAIL rstmid_new_res: got %b want 1", bus.res); end
        drain("rstmid");
    endtask

`ifdef LOGIC_REDUCE_ONES_EN
    task automatic test_ones();
        send(4'b0011, 1'b0, 2'b01);
        send(4'b0100, 1'b1, 2'b01);
        checks++; if (bus.ones_cnt !== 3'd3) begin errors++; $display("FAIL ones_cnt: got %0d want 3", bus.ones_cnt); end
        drain("ones");
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_and_hold();
        test_xor_nand();
        test_ovf();
        test_reset_mid();
`ifdef LOGIC_REDUCE_ONES_EN
        test_ones();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
